// File: rtl/urna_controller.sv
// Ballot-box sequencing controller: collects four keypad digits, confirms or
// cancels the entry, pulses one-hot vote increments, and after voting closes
// rotates the results page on a timer or on button advance.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   digit, digit_valid    keypad value and its one-cycle strobe
//   confirma, corrige     confirm / cancel strobes
//   finish_req, avanca    close-voting request / results-page advance strobes
//   estado                entry state code for the display
//   d1..d4                entered digits (d1 first)
//   finish                voting closed, results mode (sticky)
//   escolhaCandidato      results page, 0..3 candidates, 4 nulo
//   voto                  one-hot increment pulse, bit 4 = nulo
module urna_controller #(
  parameter logic [15:0] CAND0         = 16'h1234,
  parameter logic [15:0] CAND1         = 16'h2345,
  parameter logic [15:0] CAND2         = 16'h3456,
  parameter logic [15:0] CAND3         = 16'h4567,
  parameter int unsigned ROTATE_CYCLES = 50000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             confirma,
  input  logic             corrige,
  input  logic             finish_req,
  input  logic             avanca,
  output logic [2:0]       estado,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4,
  output logic             finish,
  output logic [2:0]       escolhaCandidato,
  output logic [4:0]       voto
);

  localparam int unsigned PAGE_W    = 3;
  localparam int unsigned LAST_PAGE = 4;

  // Encodings are decoded by the display and must not change.
  typedef enum logic [2:0] {
    S_DIG1 = 3'b000,
    S_DIG2 = 3'b001,
    S_DIG3 = 3'b010,
    S_DIG4 = 3'b011,
    S_CONF = 3'b100,
    S_REG  = 3'b101,
    S_BAD  = 3'b110,
    S_RST  = 3'b111
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic                fin_q, fin_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          voto_q, voto_d;
  logic                digit_ok;
  logic [15:0]         code;

  // Next-state, digit capture, vote decode and results rotation.
  always_comb begin
    state_d  = state_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    d4_d     = d4_q;
    fin_d    = fin_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    voto_d   = '0;
    digit_ok = digit_valid && (digit <= 4'd9);
    code     = {d1_q, d2_q, d3_q, d4_q};

    if (fin_q) begin
      // Entry inputs are dead in results mode; only the page timer runs.
      state_d = S_DIG1;
      if (avanca || (cnt_q == CNT_W'(ROTATE_CYCLES - 1))) begin
        cnt_d  = '0;
        page_d = (page_q == PAGE_W'(LAST_PAGE)) ? '0 : page_q + PAGE_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        S_REG, S_BAD: begin
          state_d = S_DIG1;
          d1_d = '0; d2_d = '0; d3_d = '0; d4_d = '0;
        end
        S_RST: state_d = S_DIG1;
        default: begin
          if (corrige) begin
            if (state_q != S_DIG1) begin
              state_d = S_RST;
              d1_d = '0; d2_d = '0; d3_d = '0; d4_d = '0;
            end
          end else if (confirma) begin
            if (state_q == S_CONF) begin
              state_d = S_REG;
              if      (code == CAND0) voto_d = 5'b00001;
              else if (code == CAND1) voto_d = 5'b00010;
              else if (code == CAND2) voto_d = 5'b00100;
              else if (code == CAND3) voto_d = 5'b01000;
              else                    voto_d = 5'b10000;
            end
          end else if (digit_valid) begin
            if (digit_ok) begin
              case (state_q)
                S_DIG1:  begin d1_d = digit; state_d = S_DIG2; end
                S_DIG2:  begin d2_d = digit; state_d = S_DIG3; end
                S_DIG3:  begin d3_d = digit; state_d = S_DIG4; end
                S_DIG4:  begin d4_d = digit; state_d = S_CONF; end
                default: ;
              endcase
            end
          end else if (finish_req && (state_q == S_DIG1)) begin
            fin_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DIG1;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      fin_q   <= 1'b0;
      page_q  <= '0;
      cnt_q   <= '0;
      voto_q  <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      fin_q   <= fin_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      voto_q  <= voto_d;
    end
  end

  assign estado           = state_q;
  assign d1               = d1_q;
  assign d2               = d2_q;
  assign d3               = d3_q;
  assign d4               = d4_q;
  assign finish           = fin_q;
  assign escolhaCandidato = page_q;
  assign voto             = voto_q;

endmodule

// File: tb/tb_urna_controller.sv
// Testbench for urna_controller: directed steps plus randomized strobes,
// compared every cycle against a list-of-digits reference model.
module tb_urna_controller;

  localparam int unsigned ROT   = 4;
  localparam int unsigned CNT_W = 3;

  logic       clock, reset_n;
  logic [3:0] digit;
  logic       digit_valid, confirma, corrige, finish_req, avanca;
  logic [2:0] estado, escolhaCandidato;
  logic [3:0] d1, d2, d3, d4;
  logic       finish;
  logic [4:0] voto;

  urna_controller #(
    .CAND0(16'h1234), .CAND1(16'h2345), .CAND2(16'h3456), .CAND3(16'h4567),
    .ROTATE_CYCLES(ROT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .digit(digit), .digit_valid(digit_valid),
    .confirma(confirma), .corrige(corrige), .finish_req(finish_req),
    .avanca(avanca), .estado(estado), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .finish(finish), .escolhaCandidato(escolhaCandidato), .voto(voto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: entered digits list, phase (0 entry, 1 registering,
  // 2 cancelling), results mode, page, page timer and pending vote.
  int m_n;
  int m_dig[4];
  int m_phase;
  int m_fin;
  int m_page;
  int m_cnt;
  int m_voto;
  int cands[4] = '{'h1234, 'h2345, 'h3456, 'h4567};

  task automatic model_reset();
    m_n = 0; m_phase = 0; m_fin = 0; m_page = 0; m_cnt = 0; m_voto = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic model_update(input int dv, input int dg, input int cf,
                              input int cr, input int fr, input int av);
    int code;
    m_voto = 0;
    if (m_fin != 0) begin
      if (av != 0 || m_cnt == ROT - 1) begin
        m_cnt = 0;
        m_page = (m_page + 1) % 5;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 0; m_n = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (cr != 0) begin
      if (m_n > 0) begin m_phase = 2; m_n = 0; end
    end else if (cf != 0) begin
      if (m_n == 4) begin
        code = m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3];
        m_voto = 16;
        for (int k = 0; k < 4; k++) if (code == cands[k]) m_voto = 1 << k;
        m_phase = 1;
      end
    end else if (dv != 0) begin
      if (dg <= 9 && m_n < 4) begin m_dig[m_n] = dg; m_n = m_n + 1; end
    end else if (fr != 0 && m_n == 0) begin
      m_fin = 1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e_st;
    e_st = (m_phase == 1) ? 5 : (m_phase == 2) ? 7 : m_n;
    chk({tag, ".estado"}, 16'(estado), 16'(e_st));
    chk({tag, ".d1"}, 16'(d1), 16'((m_n > 0) ? m_dig[0] : 0));
    chk({tag, ".d2"}, 16'(d2), 16'((m_n > 1) ? m_dig[1] : 0));
    chk({tag, ".d3"}, 16'(d3), 16'((m_n > 2) ? m_dig[2] : 0));
    chk({tag, ".d4"}, 16'(d4), 16'((m_n > 3) ? m_dig[3] : 0));
    chk({tag, ".finish"}, 16'(finish), 16'(m_fin));
    chk({tag, ".page"}, 16'(escolhaCandidato), 16'(m_page));
    chk({tag, ".voto"}, 16'(voto), 16'(m_voto));
  endtask

  // One clock with the given strobes; compare #1 after the edge.
  task automatic step(input string tag, input logic dv, input logic [3:0] dg,
                      input logic cf, input logic cr, input logic fr, input logic av);
    digit_valid = dv; digit = dg; confirma = cf; corrige = cr;
    finish_req = fr; avanca = av;
    @(posedge clock);
    #1;
    model_update(int'(dv), int'(dg), int'(cf), int'(cr), int'(fr), int'(av));
    check_all(tag);
    digit_valid = 0; digit = 0; confirma = 0; corrige = 0; finish_req = 0; avanca = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input string tag, input logic [3:0] dg);
    step(tag, 1, dg, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in mid-cycle, outputs checked before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clock);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    logic [15:0] c;
    int r;
    int guard;
    reset_n = 0; digit = 0; digit_valid = 0; confirma = 0; corrige = 0;
    finish_req = 0; avanca = 0;
    model_reset();
    #1;
    check_all("reset");
    #20;
    @(negedge clock);
    reset_n = 1;
    idle("idle0");

    // Candidate 0 vote and its one-cycle pulse.
    key("c0k1", 1); key("c0k2", 2); key("c0k3", 3); key("c0k4", 4);
    step("c0conf", 0, 0, 1, 0, 0, 0);
    idle("c0after"); idle("c0after2");

    // Nulo vote.
    for (int i = 0; i < 4; i++) key("nulo_k", 9);
    step("nulo_conf", 0, 0, 1, 0, 0, 0);
    idle("nulo_after");

    // Candidates 1..3.
    for (int k = 1; k < 4; k++) begin
      c = 16'(cands[k]);
      for (int i = 0; i < 4; i++) key("cand_k", 4'(c >> (12 - 4 * i)));
      step("cand_conf", 0, 0, 1, 0, 0, 0);
      idle("cand_after");
    end

    // Cancel mid entry, and cancel beating confirm at the last state.
    key("cx3", 3); key("cx4", 4);
    step("cx_corr", 0, 0, 0, 1, 0, 0);
    idle("cx_after");
    for (int i = 1; i <= 4; i++) key("cc_k", 4'(i));
    step("cc_both", 0, 0, 1, 1, 0, 0);
    idle("cc_after");

    // Invalid digit, fifth digit, finish_req outside state 000.
    key("hexB", 4'hB);
    for (int i = 5; i <= 9; i++) key("five_k", 4'(i));
    step("five_corr", 0, 0, 0, 1, 0, 0);
    idle("five_after");
    key("fr_k1", 1); key("fr_k2", 2);
    step("fr_mid", 0, 0, 0, 0, 1, 0);
    step("fr_corr", 0, 0, 0, 1, 0, 0);
    idle("fr_after");

    // Reset mid entry at estado=011, then a normal vote.
    key("rm_k1", 1); key("rm_k2", 2); key("rm_k3", 3);
    async_reset("rst_entry");
    for (int i = 1; i <= 4; i++) key("post_k", 4'(i));
    step("post_conf", 0, 0, 1, 0, 0, 0);
    idle("post_after");

    // Randomized entry traffic (one strobe at a time).
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      key("rnd_key", 4'($urandom_range(0, 11)));
      else if (r == 6) step("rnd_conf", 0, 0, 1, 0, 0, 0);
      else if (r == 7) step("rnd_corr", 0, 0, 0, 1, 0, 0);
      else             step("rnd_idle", 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    end

    // Return to 000 and close voting.
    step("fin_corr", 0, 0, 0, 1, 0, 0);
    idle("fin_i1"); idle("fin_i2");
    step("fin_req", 0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 22; n++)
      step("rot_ign", 1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // avanca at count 1, then a full hold.
    guard = 0;
    while (m_cnt != 1 && guard < 20) begin idle("seek_cnt1"); guard++; end
    total++;
    assert (guard < 20) else begin
      bad++;
      $error("FAIL seek_cnt1: observed=timeout expected=count1");
    end
    step("av_cnt1", 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 6; n++) idle("av_hold");

    // Random avanca, including collisions with timer expiry.
    for (int n = 0; n < 60; n++)
      step("rnd_av", 0, 0, 0, 0, 0, 1'($urandom_range(0, 2) == 0));

    async_reset("rst_results");
    for (int i = 1; i <= 4; i++) key("end_k", 4'(i));
    step("end_conf", 0, 0, 1, 0, 0, 0);
    idle("end_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
